// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for a RAM with one read port and one write port.
// Each port is arbitrated on its own, so a read and a write from different
// masters can issue together. A read that hits the same address as a write
// from the other master is held off one cycle so it observes the new data.
// A tag register steers the 1-cycle-latency read data back to the reader.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  // Master 0: instruction fetch
  input  logic              io_m0_req,
  input  logic              io_m0_wr,
  input  logic [ADDR_W-1:0] io_m0_addr,
  input  logic [DATA_W-1:0] io_m0_wdata,
  output logic              io_m0_gnt,
  output logic              io_m0_rvalid,
  output logic [DATA_W-1:0] io_m0_rdata,
  // Master 1: load/store unit
  input  logic              io_m1_req,
  input  logic              io_m1_wr,
  input  logic [ADDR_W-1:0] io_m1_addr,
  input  logic [DATA_W-1:0] io_m1_wdata,
  output logic              io_m1_gnt,
  output logic              io_m1_rvalid,
  output logic [DATA_W-1:0] io_m1_rdata,
  // RAM side
  output logic              io_ram_rEN,
  output logic [ADDR_W-1:0] io_ram_addrR,
  input  logic [DATA_W-1:0] io_ram_dataR,
  output logic              io_ram_wEN,
  output logic [ADDR_W-1:0] io_ram_addrW,
  output logic [DATA_W-1:0] io_ram_dataW
);

  logic r_prio;       // master favoured on the next contest (0 or 1)
  logic r_tag_valid;  // a read was granted last cycle
  logic r_tag_id;     // which master issued that read

  logic w_rd0, w_rd1, w_wr0, w_wr1;
  logic w_addr_eq;
  logic w_stall_r0, w_stall_r1;
  logic w_rd_contest, w_wr_contest;
  logic w_rd_sel, w_wr_sel;  // selected master per port (0 or 1)
  logic w_rd_go, w_wr_go;
  logic w_prio_d;

  // Port candidates, conflict detection, grant selection and next priority
  always_comb begin
    w_rd0 = io_m0_req & ~io_m0_wr;
    w_rd1 = io_m1_req & ~io_m1_wr;
    w_wr0 = io_m0_req & io_m0_wr;
    w_wr1 = io_m1_req & io_m1_wr;

    w_addr_eq  = (io_m0_addr == io_m1_addr);
    // A read colliding with the other master's write waits; no forwarding path.
    w_stall_r0 = w_rd0 & w_wr1 & w_addr_eq;
    w_stall_r1 = w_rd1 & w_wr0 & w_addr_eq;

    w_rd_contest = w_rd0 & w_rd1;
    w_wr_contest = w_wr0 & w_wr1;

    w_rd_sel = w_rd_contest ? r_prio : w_rd1;
    w_wr_sel = w_wr_contest ? r_prio : w_wr1;

    w_rd_go = (w_rd0 | w_rd1) & ~w_stall_r0 & ~w_stall_r1 & ~reset;
    w_wr_go = (w_wr0 | w_wr1) & ~reset;

    // Point priority at whoever lost or was stalled this cycle.
    w_prio_d = r_prio;
    if (w_rd_contest || w_wr_contest) begin
      w_prio_d = ~r_prio;
    end else if (w_stall_r0) begin
      w_prio_d = 1'b0;
    end else if (w_stall_r1) begin
      w_prio_d = 1'b1;
    end
  end

  // Drive grants, RAM ports and read-response routing
  always_comb begin
    io_m0_gnt = (w_rd_go & ~w_rd_sel) | (w_wr_go & ~w_wr_sel);
    io_m1_gnt = (w_rd_go & w_rd_sel) | (w_wr_go & w_wr_sel);

    io_ram_rEN   = w_rd_go;
    io_ram_addrR = w_rd_sel ? io_m1_addr : io_m0_addr;
    io_ram_wEN   = w_wr_go;
    io_ram_addrW = w_wr_sel ? io_m1_addr : io_m0_addr;
    io_ram_dataW = w_wr_sel ? io_m1_wdata : io_m0_wdata;

    io_m0_rvalid = r_tag_valid & ~r_tag_id & ~reset;
    io_m1_rvalid = r_tag_valid & r_tag_id & ~reset;
    io_m0_rdata  = io_ram_dataR;
    io_m1_rdata  = io_ram_dataR;
  end

  // Priority and response-tag registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prio      <= 1'b0;
      r_tag_valid <= 1'b0;
      r_tag_id    <= 1'b0;
    end else begin
      r_prio      <= w_prio_d;
      r_tag_valid <= w_rd_go;
      r_tag_id    <= w_rd_sel;
    end
  end

endmodule
